// File: rtl/fft_stage_sched.sv
// Radix-2 DIT butterfly issue sequencer: read/twiddle addresses per cycle, delayed write-back.
// Optional inverse-transform support (inv/tw_conj ports) when FFT_STAGE_SCHED_INV_EN is defined.
module fft_stage_sched #(
  parameter int LOG2N    = 3,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FFT_STAGE_SCHED_INV_EN
  input  logic             inv,
  output logic             tw_conj,
`endif
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-1:0] stage
);

  localparam int AW = LOG2N;
  localparam int TW = LOG2N - 1;
  localparam int D  = RD_LAT + BFLY_LAT;
  localparam int CW = $clog2(D + 1);

  localparam logic [TW-1:0] J_LAST = '1;
  localparam logic [AW-1:0] S_LAST = AW'(LOG2N - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_slot_t;

  function automatic logic [AW-1:0] span_mask(input logic [AW-1:0] s);
    return (AW'(1) << s) - AW'(1);
  endfunction

  // A = grp*2*span + pos: keep pos bits, shift the group bits up by one.
  function automatic logic [AW-1:0] addr_a_f(input logic [AW-1:0] s, input logic [TW-1:0] j);
    logic [AW-1:0] jj;
    jj = {1'b0, j};
    return ((jj & ~span_mask(s)) << 1) | (jj & span_mask(s));
  endfunction

  function automatic logic [AW-1:0] addr_b_f(input logic [AW-1:0] s, input logic [TW-1:0] j);
    return addr_a_f(s, j) | (AW'(1) << s);
  endfunction

  function automatic logic [TW-1:0] tw_f(input logic [AW-1:0] s, input logic [TW-1:0] j);
    logic [AW-1:0] pos;
    pos = {1'b0, j} & span_mask(s);
    return TW'(pos << (AW'(LOG2N - 1) - s));
  endfunction

  state_t        state_q;
  logic [TW-1:0] j_q;
  logic [AW-1:0] stage_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, rd_en_q;
  logic [AW-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [TW-1:0] tw_addr_q;
  logic [TW-1:0] j_inc;
  logic [AW-1:0] stage_inc;
  wr_slot_t      pipe_q [D];
`ifdef FFT_STAGE_SCHED_INV_EN
  logic          tw_conj_q;
`endif

  assign j_inc     = j_q + TW'(1);
  assign stage_inc = stage_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      stage_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
`ifdef FFT_STAGE_SCHED_INV_EN
      tw_conj_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            stage_q     <= '0;
            j_q         <= '0;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= addr_a_f('0, '0);
            rd_addr_b_q <= addr_b_f('0, '0);
            tw_addr_q   <= tw_f('0, '0);
`ifdef FFT_STAGE_SCHED_INV_EN
            tw_conj_q   <= inv;
`endif
          end
        end
        S_RUN: begin
          if (j_q == J_LAST) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            j_q     <= '0;
            cnt_q   <= '0;
          end else begin
            j_q         <= j_inc;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= addr_a_f(stage_q, j_inc);
            rd_addr_b_q <= addr_b_f(stage_q, j_inc);
            tw_addr_q   <= tw_f(stage_q, j_inc);
          end
        end
        S_DRAIN: begin
          // The last write of the stage lands in the final drain cycle.
          if (cnt_q == D_LAST) begin
            if (stage_q == S_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_RUN;
              stage_q     <= stage_inc;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= addr_a_f(stage_inc, '0);
              rd_addr_b_q <= addr_b_f(stage_inc, '0);
              tw_addr_q   <= tw_f(stage_inc, '0);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
`ifdef FFT_STAGE_SCHED_INV_EN
          tw_conj_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {rd_en_q, rd_addr_a_q, rd_addr_b_q};
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign stage     = stage_q;
  assign wr_en     = pipe_q[D-1].v;
  assign wr_addr_a = pipe_q[D-1].a;
  assign wr_addr_b = pipe_q[D-1].b;
`ifdef FFT_STAGE_SCHED_INV_EN
  assign tw_conj   = tw_conj_q;
`endif

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched (LOG2N=3): timing, addresses, restart and reset cases.
module tb_fft_stage_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [1:0] tw_addr;
`ifdef FFT_STAGE_SCHED_INV_EN
  logic       inv = 1'b0;
  logic       tw_conj;
  bit         inv_req = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } vec_t;
  vec_t vec [12];

  always #5 clk = ~clk;

  fft_stage_sched #(.LOG2N(3), .RD_LAT(1), .BFLY_LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef FFT_STAGE_SCHED_INV_EN
    .inv       (inv),
    .tw_conj   (tw_conj),
`endif
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Issue slot for cycle c of a run whose start was accepted at edge 0.
  function automatic int rd_index(input int c);
    int s, off;
    if (c < 1) return -1;
    s   = (c - 1) / 9;
    off = (c - 1) % 9;
    if (s < 3 && off < 4) return s * 4 + off;
    return -1;
  endfunction

  task automatic check_zero(input string name, input int cyc);
    chk({name, "_busy"}, cyc, 32'(busy), 32'd0);
    chk({name, "_done"}, cyc, 32'(done), 32'd0);
    chk({name, "_rd_en"}, cyc, 32'(rd_en), 32'd0);
    chk({name, "_rd_a"}, cyc, 32'(rd_addr_a), 32'd0);
    chk({name, "_rd_b"}, cyc, 32'(rd_addr_b), 32'd0);
    chk({name, "_tw"}, cyc, 32'(tw_addr), 32'd0);
    chk({name, "_wr_en"}, cyc, 32'(wr_en), 32'd0);
    chk({name, "_wr_a"}, cyc, 32'(wr_addr_a), 32'd0);
    chk({name, "_wr_b"}, cyc, 32'(wr_addr_b), 32'd0);
    chk({name, "_stage"}, cyc, 32'(stage), 32'd0);
`ifdef FFT_STAGE_SCHED_INV_EN
    chk({name, "_tw_conj"}, cyc, 32'(tw_conj), 32'd0);
`endif
  endtask

  // Caller is at a negedge in IDLE; start is sampled at the next posedge (edge 0).
  task automatic run_check(input int ncyc, input bit hold);
    int ri, wi, es;
    int last = -1;
    start = 1'b1;
`ifdef FFT_STAGE_SCHED_INV_EN
    inv = inv_req;
`endif
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      ri = rd_index(c);
      wi = rd_index(c - 5);
      $display("cyc=%0d busy=%0b done=%0b rd=%0b a=%0d b=%0d tw=%0d wr=%0b wa=%0d wb=%0d stage=%0d",
               c, busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b, stage);
      chk("busy", c, 32'(busy), 32'(c <= 28));
      chk("done", c, 32'(done), 32'(c == 28));
      chk("rd_en", c, 32'(rd_en), 32'(ri >= 0));
      if (ri >= 0) begin
        chk("rd_a", c, 32'(rd_addr_a), 32'(vec[ri].a));
        chk("rd_b", c, 32'(rd_addr_b), 32'(vec[ri].b));
        chk("tw", c, 32'(tw_addr), 32'(vec[ri].tw));
        last = ri;
      end else if (last >= 0) begin
        chk("hold_a", c, 32'(rd_addr_a), 32'(vec[last].a));
        chk("hold_b", c, 32'(rd_addr_b), 32'(vec[last].b));
        chk("hold_tw", c, 32'(tw_addr), 32'(vec[last].tw));
      end
      chk("wr_en", c, 32'(wr_en), 32'(wi >= 0));
      if (wi >= 0) begin
        chk("wr_a", c, 32'(wr_addr_a), 32'(vec[wi].a));
        chk("wr_b", c, 32'(wr_addr_b), 32'(vec[wi].b));
      end
      if (c <= 28) begin
        es = (c - 1) / 9;
        if (es > 2) es = 2;
        chk("stage", c, 32'(stage), es);
      end
`ifdef FFT_STAGE_SCHED_INV_EN
      chk("tw_conj", c, 32'(tw_conj), 32'(inv_req && (c <= 28)));
`endif
    end
  endtask

  initial begin
    vec[0]  = '{3'd0, 3'd1, 2'd0};
    vec[1]  = '{3'd2, 3'd3, 2'd0};
    vec[2]  = '{3'd4, 3'd5, 2'd0};
    vec[3]  = '{3'd6, 3'd7, 2'd0};
    vec[4]  = '{3'd0, 3'd2, 2'd0};
    vec[5]  = '{3'd1, 3'd3, 2'd2};
    vec[6]  = '{3'd4, 3'd6, 2'd0};
    vec[7]  = '{3'd5, 3'd7, 2'd2};
    vec[8]  = '{3'd0, 3'd4, 2'd0};
    vec[9]  = '{3'd1, 3'd5, 2'd1};
    vec[10] = '{3'd2, 3'd6, 2'd2};
    vec[11] = '{3'd3, 3'd7, 2'd3};

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 0, 32'(busy), 32'd0);

    // Single start pulse: full three-stage run plus idle tail
    run_check(32, 1'b0);

    // Start held high throughout: no restart until IDLE is reached
    run_check(28, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("restart_busy", 29, 32'(busy), 32'd0);
    chk("restart_done", 29, 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("restart_busy", 30, 32'(busy), 32'd1);
    chk("restart_rd_en", 30, 32'(rd_en), 32'd1);
    chk("restart_rd_a", 30, 32'(rd_addr_a), 32'd0);
    chk("restart_rd_b", 30, 32'(rd_addr_b), 32'd1);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid stage 1 (cycle 12)
    run_check(12, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst", 12);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_wr_en", i, 32'(wr_en), 32'd0);
      chk("post_rst_busy", i, 32'(busy), 32'd0);
    end
    run_check(32, 1'b0);

`ifdef FFT_STAGE_SCHED_INV_EN
    inv_req = 1'b1;
    run_check(32, 1'b0);
    inv_req = 1'b0;
    run_check(32, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
